// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline state encoding and EX/MEM payload width
package pipe_pkg;
  localparam int EM_PAYLOAD_W = 82;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: synchronous-clear counter that sticks at its all-ones value
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (clear) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry skid buffer with registered in_ready, flush and stall counter
module pipe_skid_buffer
  import pipe_pkg::*;
#(
  parameter int DATA_W = EM_PAYLOAD_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  state_t state, nxt;
  logic [DATA_W-1:0] skid;
  logic in_fire, out_fire;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_valid = state != EMPTY;
  assign occupancy = state;
  always_comb begin
    nxt = flush ? EMPTY :
          state == EMPTY ? (in_fire ? ONE : EMPTY) :
          state == ONE ? ((in_fire && !out_fire) ? FULL : (!in_fire && out_fire) ? EMPTY : ONE) :
          (out_ready ? ONE : FULL);
  end
  // in_ready is registered from the next state so out_ready never reaches it combinationally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
      out_data <= '0;
      skid     <= '0;
    end else begin
      state    <= nxt;
      in_ready <= nxt != FULL;
      if (state == FULL && out_ready) out_data <= skid;
      else if (in_fire && (state == EMPTY || out_fire)) out_data <= in_data;
      if (state == ONE && in_fire && !out_fire) skid <= in_data;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk  (clk),
    .clear(!rst_n),
    .inc  (out_valid && !out_ready),
    .cnt  (stall_cnt)
  );
endmodule

// File: tb/tb_pipe_skid_buffer.sv
// tb_pipe_skid_buffer: directed stimulus with a queue scoreboard checked by an output monitor
module tb_pipe_skid_buffer;
  logic clk = 0, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, out_data;
  logic [1:0] occupancy;
  logic [3:0] stall_cnt;
  logic [15:0] exp_q[$];
  int tests = 0, fails = 0;

  pipe_skid_buffer #(.DATA_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // every downstream transfer must match the oldest expected payload
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got %0h expected none", out_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          fails++;
          $display("FAIL out_data: got %0h expected %0h", out_data, e);
        end
      end
    end
  end

  initial begin
    rst_n = 0; flush = 0; in_valid = 1; in_data = 16'h5555; out_ready = 0;
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_occ", occupancy, 0);
    rst_n = 1; in_valid = 0;
    step();
    chk("rel_in_ready", in_ready, 1);

    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1; in_data = 16'(i); exp_q.push_back(16'(i));
      step();
      chk("stream_occ", occupancy, 1);
      chk("stream_data", out_data, i);
    end
    in_valid = 0;
    step();
    chk("stream_stall", stall_cnt, 0);
    chk("stream_drain_occ", occupancy, 0);

    out_ready = 0;
    in_valid = 1; in_data = 16'hAAAA; exp_q.push_back(16'hAAAA);
    step();
    in_data = 16'hBBBB; exp_q.push_back(16'hBBBB);
    step();
    chk("bp_full_occ", occupancy, 2);
    chk("bp_in_ready", in_ready, 0);
    in_data = 16'hCCCC;
    step(); step();
    chk("bp_hold_occ", occupancy, 2);
    chk("bp_hold_ready", in_ready, 0);
    chk("bp_head", out_data, 16'hAAAA);
    chk("bp_stall", stall_cnt, 3);
    out_ready = 1;
    step();
    chk("bp_release_ready", in_ready, 1);
    exp_q.push_back(16'hCCCC);
    step();
    in_valid = 0;
    step();
    chk("bp_end_stall", stall_cnt, 3);
    chk("bp_end_occ", occupancy, 0);
    chk("bp_queue_empty", exp_q.size(), 0);

    out_ready = 0;
    in_valid = 1; in_data = 16'h1111; exp_q.push_back(16'h1111);
    step();
    in_data = 16'h2222; exp_q.push_back(16'h2222);
    step();
    chk("fl_full", occupancy, 2);
    flush = 1; in_data = 16'h1234;
    step();
    exp_q.delete();
    chk("fl_out_valid", out_valid, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_stall_kept", stall_cnt, 5);
    flush = 0; in_valid = 0; out_ready = 1;
    step(); step();
    chk("fl_stay_empty", occupancy, 0);

    out_ready = 0;
    in_valid = 1; in_data = 16'h7777; exp_q.push_back(16'h7777);
    step();
    in_valid = 0;
    repeat (5) step();
    chk("sat_mid", stall_cnt, 10);
    repeat (15) step();
    chk("sat_top", stall_cnt, 15);
    chk("sat_occ", occupancy, 1);

    in_valid = 1; in_data = 16'h8888;
    step();
    chk("mr_full", occupancy, 2);
    rst_n = 0; in_valid = 0;
    step();
    exp_q.delete();
    chk("mr_out_valid", out_valid, 0);
    chk("mr_occ", occupancy, 0);
    chk("mr_stall", stall_cnt, 0);
    chk("mr_data", out_data, 0);
    chk("mr_in_ready", in_ready, 0);
    rst_n = 1; out_ready = 1;
    step();
    chk("mr_rel_ready", in_ready, 1);
    chk("mr_rel_valid", out_valid, 0);
    step();

    in_valid = 1; in_data = 16'h9999; exp_q.push_back(16'h9999);
    step();
    chk("post_data", out_data, 16'h9999);
    in_valid = 0;
    step();
    chk("post_queue_empty", exp_q.size(), 0);
    chk("post_occ", occupancy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_skid_buffer.md
PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

Interface
REQ-001 Parameter DATA_W, default 82, payload width in bits (EX/MEM payload size).
REQ-002 Parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-003 Port clk, input, 1, single clock; every register updates on its rising edge.
REQ-004 Port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 Port flush, input, 1, synchronous kill of all buffered entries.
REQ-006 Port in_valid, input, 1, upstream payload valid.
REQ-007 Port in_data, input, DATA_W, upstream payload.
REQ-008 Port in_ready, output, 1, buffer can accept this cycle.
REQ-009 Port out_valid, output, 1, downstream payload valid.
REQ-010 Port out_data, output, DATA_W, downstream payload.
REQ-011 Port out_ready, input, 1, downstream accepts this cycle.
REQ-012 Port occupancy, output, 2, number of held entries (0..2).
REQ-013 Port stall_cnt, output, CNT_W, saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 Input transfer occurs when in_valid and in_ready are both 1; output transfer occurs when out_valid and out_ready are both 1.
REQ-015 Storage: main register (drives out_data) and skid register; FIFO order preserved.
REQ-016 States: EMPTY (occupancy 0), ONE (main valid), FULL (main and skid valid).
REQ-017 in_ready = 1 in EMPTY and ONE, 0 in FULL; decoded from registered state only, with no combinational path from out_ready.
REQ-018 out_valid = 1 in ONE and FULL; out_data = main register.
REQ-019 EMPTY: in_valid -> ONE, main <= in_data; else stay EMPTY.
REQ-020 ONE with input and output transfer: stay ONE, main <= in_data.
REQ-021 ONE with input transfer only: -> FULL, skid <= in_data.
REQ-022 ONE with output transfer only: -> EMPTY.
REQ-023 ONE with neither transfer: hold.
REQ-024 FULL with out_ready: -> ONE, main <= skid. FULL with out_ready=0: hold. in_data is ignored in FULL.
REQ-025 Latency is 1 cycle from an input transfer in EMPTY to out_valid=1; throughput is 1 transfer/cycle in ONE with out_ready held high.
REQ-026 flush=1 forces the state to EMPTY at the next edge and overrides every transition. An input offered in the flush cycle is discarded. An output transfer in the flush cycle still counts as completed downstream.
REQ-027 Data registers do not clear on flush; only the valid state clears.
REQ-028 stall_cnt increments by 1 each cycle with out_valid=1 and out_ready=0, saturates at 2^CNT_W-1, and is not cleared by flush.
REQ-029 Payload is opaque: no bit of in_data is interpreted or modified.

Reset
REQ-030 rst_n=0 sampled at an edge sets: state EMPTY, occupancy 0, out_valid 0, stall_cnt 0, main and skid registers all-zero, so out_data = 0.
REQ-031 in_ready is 0 while rst_n=0 and 1 on the first cycle after release.
REQ-032 rst_n low takes priority over flush and all transfers, including mid-operation in FULL.

Structure
REQ-033 Shared package pipe_pkg holds: state enum typedef (EMPTY/ONE/FULL) and constant EM_PAYLOAD_W = 82.
REQ-034 Single module; the saturating counter may be factored into sub-module sat_counter (parameter CNT_W, inputs inc and clear).
REQ-035 The EX/MEM stage instantiates pipe_skid_buffer with DATA_W = EM_PAYLOAD_W.

Verification
REQ-036 Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=0, stall_cnt=0; after release, in_ready=1.
REQ-037 Streaming, DATA_W=16, out_ready=1: inputs 0x0001..0x0008 on consecutive cycles -> outputs appear 1 cycle later in order, occupancy stays 1, stall_cnt=0.
REQ-038 Backpressure: send 0xAAAA then 0xBBBB with out_ready=0 -> FULL, in_ready=0, occupancy=2; 0xCCCC offered meanwhile is not accepted. Raise out_ready -> outputs 0xAAAA, 0xBBBB, then 0xCCCC; stall_cnt equals the number of stalled cycles.
REQ-039 Flush in FULL with in_valid=1 (0x1234) -> next cycle EMPTY, out_valid=0, occupancy=0, 0x1234 never emitted.
REQ-040 Saturation, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-041 Reset mid-operation: rst_n=0 for 1 cycle while FULL -> EMPTY, out_valid=0, stall_cnt=0, buffered data never emitted.
